// File: rtl/mul_eval_pkg.sv
// Purpose: shared widths, FSM state encoding and accumulator record for the multiplier error sweeper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mul_eval_pkg;

    // Operand, product and accumulator widths
    localparam int unsigned OPND_W = 4;
    localparam int unsigned PROD_W = 8;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned SUM_W  = 16;

    // Vector index width: one bit per operand bit of both operands
    localparam int unsigned IDX_W  = 2 * OPND_W;

    // Hold counter covers SETTLE values 0..7
    localparam int unsigned HOLD_W = 3;

    // Last vector of a sweep
    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Result accumulators, kept together so clear/hold is a single assignment
    typedef struct packed {
        logic [CNT_W-1:0]  err_count;
        logic [SUM_W-1:0]  sum_err;
        logic [PROD_W-1:0] max_err;
    } acc_t;

endpackage

// File: rtl/mul_err_calc.sv
// Purpose: exact 4x4 unsigned product and |exact - po| magnitude for one test vector.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
//
// Ports:
//   a, b     operands applied to the multiplier under test
//   po       product returned by the multiplier under test
//   exact    reference product a*b (max 225, fits 8 bits)
//   abs_err  magnitude of exact - po (0..255)
module mul_err_calc
    import mul_eval_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [PROD_W-1:0] po,
    output logic [PROD_W-1:0] exact,
    output logic [PROD_W-1:0] abs_err
);

    logic signed [PROD_W:0] diff;
    logic signed [PROD_W:0] diff_neg;

    always_comb begin
        exact    = PROD_W'(a) * PROD_W'(b);
        // One extra bit so exact - po cannot wrap; both operands are non-negative
        diff     = $signed({1'b0, exact}) - $signed({1'b0, po});
        diff_neg = -diff;
        // |diff| never exceeds 255, so the low 8 bits hold the full magnitude
        abs_err  = diff[PROD_W] ? diff_neg[PROD_W-1:0] : diff[PROD_W-1:0];
    end

endmodule

// File: rtl/mul_err_sweeper.sv
// Purpose: drive all 256 operand pairs into an external 4x4 multiplier and accumulate error statistics.
// Latency: done pulses 256*(SETTLE+1)+1 cycles after the accepted start cycle.
// Backpressure: none; start is ignored while busy or finishing, abort ends a sweep on the next edge.
//
// Ports:
//   clk, rst    single clock, synchronous active-high reset
//   start       one-cycle sweep request (accepted only in IDLE without abort)
//   abort       stop a running sweep; partial results are kept
//   pi / po     vector to / product from the multiplier under test (a = pi[3:0], b = pi[7:4])
//   busy, done  busy while sweeping; done is a one-cycle completion pulse
//   err_count, sum_err, max_err   error statistics, held stable in IDLE
module mul_err_sweeper
    import mul_eval_pkg::*;
#(
    parameter int unsigned SETTLE = 0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [IDX_W-1:0]  pi,
    input  logic [PROD_W-1:0] po,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic [SUM_W-1:0]  sum_err,
    output logic [PROD_W-1:0] max_err
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [HOLD_W-1:0] hold_cnt;
    acc_t              acc;
    acc_t              acc_next;

    logic [PROD_W-1:0] exact;
    logic [PROD_W-1:0] abs_err;
    logic              err_hit;
    logic              last_hold;

    mul_err_calc u_calc (
        .a       (idx[OPND_W-1:0]),
        .b       (idx[IDX_W-1:OPND_W]),
        .po      (po),
        .exact   (exact),
        .abs_err (abs_err)
    );

    assign err_hit   = (po != exact);
    assign last_hold = (hold_cnt == HOLD_LAST);

    // Accumulator update for the vector currently on pi
    always_comb begin
        acc_next           = acc;
        acc_next.err_count = acc.err_count + CNT_W'(err_hit);
        acc_next.sum_err   = acc.sum_err + SUM_W'(abs_err);
        if (abs_err > acc.max_err) begin
            acc_next.max_err = abs_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            hold_cnt <= '0;
            acc      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // abort in the same cycle vetoes the start
                    if (start && !abort) begin
                        state    <= ST_SWEEP;
                        idx      <= '0;
                        hold_cnt <= '0;
                        acc      <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (abort) begin
                        // The vector on pi this cycle is not sampled
                        state <= ST_IDLE;
                    end else if (last_hold) begin
                        hold_cnt <= '0;
                        acc      <= acc_next;
                        if (idx == IDX_LAST) begin
                            // idx stays at the last vector; no wrap inside a sweep
                            state <= ST_FINISH;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pi        = idx;
    assign busy      = (state == ST_SWEEP);
    assign done      = (state == ST_FINISH);
    assign err_count = acc.err_count;
    assign sum_err   = acc.sum_err;
    assign max_err   = acc.max_err;

endmodule

// File: tb/tb_mul_err_sweeper.sv
module tb_mul_err_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0;
    logic        start3;
    logic        abort;
    logic [7:0]  pi0, po0, pi3, po3;
    logic        busy0, done0, busy3, done3;
    logic [8:0]  err0, err3;
    logic [15:0] sum0, sum3;
    logic [7:0]  max0, max3;
    int          mode0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Multiplier-under-test models: 0 exact, 1 stuck at zero, 2 exact with LSB flipped
    function automatic logic [7:0] mul_model(input int mode, input logic [7:0] v);
        logic [7:0] ex;
        ex = 8'(v[3:0]) * 8'(v[7:4]);
        case (mode)
            1:       return 8'h00;
            2:       return ex ^ 8'h01;
            default: return ex;
        endcase
    endfunction

    assign po0 = mul_model(mode0, pi0);
    assign po3 = mul_model(0, pi3);

    mul_err_sweeper #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort),
        .pi(pi0), .po(po0), .busy(busy0), .done(done0),
        .err_count(err0), .sum_err(sum0), .max_err(max0)
    );

    mul_err_sweeper #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort),
        .pi(pi3), .po(po3), .busy(busy3), .done(done3),
        .err_count(err3), .sum_err(sum3), .max_err(max3)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs a SETTLE=0 sweep. ev_kind: 0 none, 1 start pulse, 2 rst, 3 abort, applied in cycle ev_cyc.
    // For rst/abort the task returns in cycle ev_cyc+1 for the caller to inspect.
    task automatic sweep0(input int ev_cyc, input int ev_kind, output int done_cyc);
        done_cyc = -1;
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            if (ev_kind >= 2 && c == ev_cyc + 1) begin
                rst   = 1'b0;
                abort = 1'b0;
                break;
            end
            if (ev_kind == 1 && c == ev_cyc + 1) start0 = 1'b0;
            if (done0) begin
                done_cyc = c;
                chk("busy_with_done", busy0, 0);
                break;
            end
            if (c == 1 || c == 2 || c == 101 || c == 256) begin
                chk($sformatf("pi0_c%0d", c), pi0, c - 1);
                chk($sformatf("busy0_c%0d", c), busy0, 1);
            end
            if (c == ev_cyc) begin
                if (ev_kind == 1) start0 = 1'b1;
                if (ev_kind == 2) rst    = 1'b1;
                if (ev_kind == 3) abort  = 1'b1;
            end
            tick();
        end
    endtask

    typedef struct {
        int mode;
        int exp_done;
        int exp_err;
        int exp_sum;
        int exp_max;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int dc;
        int pulses;

        vecs[0] = '{mode: 1, exp_done: 257, exp_err: 225, exp_sum: 14400, exp_max: 225};
        vecs[1] = '{mode: 0, exp_done: 257, exp_err: 0,   exp_sum: 0,     exp_max: 0};
        vecs[2] = '{mode: 2, exp_done: 257, exp_err: 256, exp_sum: 256,   exp_max: 1};

        rst = 1'b1; start0 = 1'b0; start3 = 1'b0; abort = 1'b0; mode0 = 0;
        repeat (3) tick();
        chk("rst_pi0", pi0, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_err0", err0, 0);
        chk("rst_sum0", sum0, 0);
        chk("rst_max0", max0, 0);
        chk("rst_busy3", busy3, 0);
        rst = 1'b0;
        tick();

        // Full sweeps with different multiplier behaviours
        for (int i = 0; i < 3; i++) begin
            mode0 = vecs[i].mode;
            sweep0(0, 0, dc);
            chk($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_done);
            chk($sformatf("v%0d_err_count", i), err0, vecs[i].exp_err);
            chk($sformatf("v%0d_sum_err", i), sum0, vecs[i].exp_sum);
            chk($sformatf("v%0d_max_err", i), max0, vecs[i].exp_max);
            tick();
            chk($sformatf("v%0d_done_one_cycle", i), done0, 0);
            chk($sformatf("v%0d_busy_after", i), busy0, 0);
            repeat (5) tick();
            chk($sformatf("v%0d_err_hold", i), err0, vecs[i].exp_err);
            chk($sformatf("v%0d_sum_hold", i), sum0, vecs[i].exp_sum);
        end

        // start pulsed mid-sweep is ignored
        mode0 = 0;
        sweep0(100, 1, dc);
        chk("restart_done_cycle", dc, 257);
        chk("restart_err", err0, 0);
        tick();

        // rst mid-sweep
        mode0 = 1;
        sweep0(100, 2, dc);
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        chk("midrst_pi", pi0, 0);
        chk("midrst_err", err0, 0);
        chk("midrst_sum", sum0, 0);
        chk("midrst_max", max0, 0);
        repeat (3) tick();
        chk("midrst_idle", busy0, 0);

        // abort at cycle 50 with po = 0: vectors 0..48 were sampled
        mode0 = 1;
        sweep0(50, 3, dc);
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_err", err0, 30);
        chk("abort_sum", sum0, 360);
        chk("abort_max", max0, 30);
        pulses = 0;
        for (int c = 0; c < 300; c++) begin
            if (done0) pulses++;
            tick();
        end
        chk("abort_no_done", pulses, 0);

        // abort and start together in IDLE: no sweep, results unchanged
        abort = 1'b1; start0 = 1'b1;
        tick();
        abort = 1'b0; start0 = 1'b0;
        chk("abort_start_busy", busy0, 0);
        repeat (3) tick();
        chk("abort_start_idle", busy0, 0);
        chk("abort_start_err_hold", err0, 30);

        // SETTLE=3: each vector held four cycles, done at 1025
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        dc = -1;
        for (int c = 1; c <= 1100; c++) begin
            if (done3) begin
                dc = c;
                break;
            end
            if (c == 1 || c == 4 || c == 5 || c == 8 || c == 9 || c == 1024)
                chk($sformatf("pi3_c%0d", c), pi3, (c - 1) / 4);
            tick();
        end
        chk("s3_done_cycle", dc, 1025);
        chk("s3_err", err3, 0);
        chk("s3_sum", sum3, 0);
        chk("s3_max", max3, 0);
        tick();
        chk("s3_done_one_cycle", done3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
